// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl
// Description : Debug-path register file dumper. On a start pulse it takes
//               the register file's debug read port (debug_on_o), walks
//               addresses 0..NUM_REGS-1 and serializes each 32-bit word
//               MSB-first onto a valid/ready byte stream for the debug UART.
//               Optional feature macro: REGDUMP_CHECKSUM_EN appends an 8-bit
//               XOR checksum of all data bytes as a final byte.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk               system clock (register file samples address on negedge)
//   rst               asynchronous active-high reset
//   start_i           one-cycle dump request, ignored unless idle
//   reg_debug_data_i  debug read data from the register file
//   debug_on_o        selects the debug read path, high for the whole dump
//   read_reg_debug_o  register address being read
//   tx_data_o         byte to transmit
//   tx_valid_o        tx_data_o is valid
//   tx_ready_i        transmitter accepts the byte when valid & ready
//   busy_o            dump in progress
//   done_o            one-cycle pulse after the last byte is accepted
// ============================================================================
module regfile_dump_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32   // fixed at 32: four bytes per register
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] reg_debug_data_i,
    output logic              debug_on_o,
    output logic [ADDR_W-1:0] read_reg_debug_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_SEND  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
`ifdef REGDUMP_CHECKSUM_EN
       ,S_CSUM  = 3'd7
`endif
    } state_t;

    state_t              state_q,    state_d;
    logic                debug_on_q, debug_on_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic [1:0]          cnt_q,      cnt_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [7:0]          csum_q,     csum_d;
`endif

    logic                w_accept;
    logic                w_finish;

    assign w_accept = tx_valid_q & tx_ready_i;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            debug_on_q <= 1'b0;
            addr_q     <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= 2'd0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            debug_on_q <= debug_on_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        debug_on_d = debug_on_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        w_finish   = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_SETUP;
                    busy_d     = 1'b1;
                    debug_on_d = 1'b1;
                    addr_d     = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end

            // Address is stable across the negedge where the register file
            // samples it; WAIT gives the returned data a full guard cycle.
            S_SETUP: state_d = S_WAIT;
            S_WAIT:  state_d = S_LOAD;

            S_LOAD: begin
                shift_d    = reg_debug_data_i;
                cnt_d      = 2'd0;
                tx_data_d  = reg_debug_data_i[DATA_W-1 -: 8];
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (w_accept) begin
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d = csum_q ^ tx_data_q;
`endif
                    if (cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_NEXT;
                    end else begin
                        // Rotate rather than zero-fill so every bit of the
                        // word is consumed; the byte order seen is identical.
                        shift_d   = {shift_q[DATA_W-9:0], shift_q[DATA_W-1 -: 8]};
                        tx_data_d = shift_q[DATA_W-9 -: 8];
                        cnt_d     = cnt_q + 2'd1;
                    end
                end
            end

            S_NEXT: begin
                if (addr_q == c_LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                    tx_data_d  = csum_q;
                    tx_valid_d = 1'b1;
                    state_d    = S_CSUM;
`else
                    w_finish   = 1'b1;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_SETUP;
                end
            end

`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    tx_valid_d = 1'b0;
                    w_finish   = 1'b1;
                end
            end
`endif

            S_DONE:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // Common exit into DONE: release the read port and pulse done
        if (w_finish) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            debug_on_d = 1'b0;
            addr_d     = '0;
        end
    end

    assign debug_on_o       = debug_on_q;
    assign read_reg_debug_o = addr_q;
    assign tx_data_o        = tx_data_q;
    assign tx_valid_o       = tx_valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_ctrl
// Description : Self-checking bench for regfile_dump_ctrl. A register-file
//               model answers debug reads; the expected byte stream is built
//               from the register array (plus XOR checksum when
//               REGDUMP_CHECKSUM_EN is defined) and compared with the bytes
//               accepted on the valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   reg_debug_data;
    logic          debug_on;
    logic [AW-1:0] read_reg_debug;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    regfile_dump_ctrl #(
        .NUM_REGS (NREGS),
        .ADDR_W   (AW),
        .DATA_W   (32)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .reg_debug_data_i (reg_debug_data),
        .debug_on_o       (debug_on),
        .read_reg_debug_o (read_reg_debug),
        .tx_data_o        (tx_data),
        .tx_valid_o       (tx_valid),
        .tx_ready_i       (tx_ready),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          busy_cnt, dbg_cnt, done_cnt, done_cyc, start_cyc;
    bit          rand_ready;
    bit          track;
    logic [31:0] r [NREGS];
    logic [7:0]  exp_q [$];
    logic [7:0]  got   [$];

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream: each register MSB first, then the XOR of all bytes
    task automatic build_expected();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(r[i][8*b +: 8]);
                x = x ^ r[i][8*b +: 8];
            end
        end
        if (CS == 1) exp_q.push_back(x);
    endtask

    // One clock cycle: act at the negedge, away from the active edge
    task automatic tick();
        int idx;
        @(negedge clk);
        cyc++;
        reg_debug_data = debug_on ? r[read_reg_debug] : $urandom;
        if (busy)     busy_cnt++;
        if (debug_on) dbg_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_value("done_released", {30'd0, busy, debug_on}, 32'd0);
        end
        if (track && tx_valid) begin
            idx = got.size();
            if (idx < exp_q.size()) begin
                check_value($sformatf("tx_byte%0d", idx), {24'd0, tx_data}, {24'd0, exp_q[idx]});
                check_value($sformatf("tx_addr%0d", idx), {27'd0, read_reg_debug},
                            (idx / 4 < NREGS) ? 32'(idx / 4) : 32'(NREGS - 1));
            end
        end
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready) got.push_back(tx_data);
    endtask

    task automatic compare_stream(input string tag);
        check_value({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_value($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic run_dump(input string tag, input bit rr, input int restart_at);
        build_expected();
        got.delete();
        busy_cnt = 0; dbg_cnt = 0; done_cnt = 0; done_cyc = 0;
        rand_ready = rr;
        track = 1'b1;
        tick();
        start = 1'b1;
        start_cyc = cyc;
        for (int n = 1; n <= 4000 && done_cnt == 0; n++) begin
            tick();
            start = (n == restart_at);
        end
        start = 1'b0;
        check_value({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
        if (!rr) begin
            // Start cycle and done cycle both count: 1 + 8 per register + 1
            check_value({tag, "_latency"}, 32'(done_cyc - start_cyc + 1), 32'(2 + 8 * NREGS + CS));
            check_value({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(8 * NREGS + CS));
            check_value({tag, "_dbg_cycles"}, 32'(dbg_cnt), 32'(8 * NREGS + CS));
        end
        repeat (5) tick();
        check_value({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check_value({tag, "_idle_after"}, {29'd0, busy, debug_on, tx_valid}, 32'd0);
        compare_stream(tag);
        track = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < NREGS; i++) r[i] = 32'h1122_3300 + 32'(i);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1; reg_debug_data = '0;
        rand_ready = 1'b0; track = 1'b0;
        busy_cnt = 0; dbg_cnt = 0; done_cnt = 0; done_cyc = 0; start_cyc = 0;
        fill_pattern();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_value("rst_ctrl", {28'd0, debug_on, tx_valid, busy, done}, 32'd0);
        check_value("rst_addr", {27'd0, read_reg_debug}, 32'd0);
        check_value("rst_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;

        // Idle with no start
        for (int i = 0; i < 10; i++) begin
            tick();
            check_value("idle", {23'd0, debug_on, tx_valid, busy, done, read_reg_debug}, 32'd0);
        end

        // Known pattern, tx_ready high
        fill_pattern();
        run_dump("pat", 1'b0, -1);

        // Same pattern under random back-pressure
        run_dump("bp", 1'b1, -1);

        // Start re-pulsed mid-dump must be ignored
        run_dump("restart", 1'b0, 40);

        // Reset while byte 2 of register 7 is presented
        fill_pattern();
        build_expected();
        got.delete();
        done_cnt = 0;
        rand_ready = 1'b0;
        track = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 2000 && got.size() < 31; n++) tick();
        check_value("pre_rst_addr", {27'd0, read_reg_debug}, 32'd7);
        check_value("pre_rst_byte", {24'd0, tx_data}, 32'h33);
        rst = 1'b1;
        #1;
        check_value("rst_async", {28'd0, debug_on, tx_valid, busy, done}, 32'd0);
        check_value("rst_async_addr", {27'd0, read_reg_debug}, 32'd0);
        track = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_value("rst_no_done", 32'(done_cnt), 32'd0);

        // Fresh dump after reset starts from register 0
        for (int i = 0; i < NREGS; i++) r[i] = $urandom;
        run_dump("post_rst", 1'b0, -1);

        // Checksum patterns: r[i]=i, then single 0xFF in the top byte of r[0]
        for (int i = 0; i < NREGS; i++) r[i] = 32'(i);
        run_dump("ident", 1'b0, -1);
        for (int i = 0; i < NREGS; i++) r[i] = 32'h0;
        r[0] = 32'hFF00_0000;
        run_dump("ff", 1'b0, -1);

        // Random data with random back-pressure
        for (int i = 0; i < NREGS; i++) r[i] = $urandom;
        run_dump("rnd", 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
